// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: state encodings and default bus widths.
package mem_responder_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 26;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StAck     = 2'd2,
    StIllegal = 2'd3
  } state_e;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } op_e;

endpackage

// File: rtl/mem_resp_array.sv
// Word-addressed storage for mem_responder: synchronous write, registered read, no reset.
module mem_resp_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: wait states, write commit / read drive, four-phase READY handshake.
// Optional wait-state counter and WAIT state built only when MEM_RESP_WAIT_EN is defined.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  inout  wire  [DATA_WIDTH-1:0] DATA,
  output logic                  READY,
  output logic                  ERR
);

  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 0..15");
  end
  if (ADDR_WIDTH <= DEPTH_LOG2) begin : g_bad_addr
    $error("ADDR_WIDTH must exceed DEPTH_LOG2");
  end

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic                  acc_q, acc_d;
  logic                  oor_q, oor_d;
  logic                  err_q, err_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
`ifdef MEM_RESP_WAIT_EN
  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);
  logic [3:0]            cnt_q, cnt_d;
`endif

  logic                  go_ack;
  logic                  arr_we;
  logic                  arr_re;
  logic [DATA_WIDTH-1:0] arr_rdata;

  mem_resp_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i  (CLK),
    .we_i   (arr_we),
    .waddr_i(addr_q),
    .wdata_i(wdata_q),
    .re_i   (arr_re),
    .raddr_i(ADDR[DEPTH_LOG2-1:0]),
    .rdata_o(arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    oor_d   = oor_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_RESP_WAIT_EN
    cnt_d   = cnt_q;
`endif
    go_ack  = 1'b0;
    arr_we  = 1'b0;
    arr_re  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // acc_q marks the cycle after the request edge, while the array read settles.
        if (acc_q) begin
          acc_d = 1'b0;
`ifdef MEM_RESP_WAIT_EN
          if (cnt_q != 4'd0) begin
            state_d = StWait;
          end else begin
            go_ack = 1'b1;
          end
`else
          go_ack = 1'b1;
`endif
        end else if (READ && WRITE) begin
          state_d = StIllegal;
          err_d   = 1'b1;
        end else if (READ || WRITE) begin
          acc_d  = 1'b1;
          op_d   = WRITE ? OpWrite : OpRead;
          addr_d = ADDR[DEPTH_LOG2-1:0];
          oor_d  = |ADDR[ADDR_WIDTH-1:DEPTH_LOG2];
          arr_re = READ;
          if (WRITE) begin
            wdata_d = DATA;
          end
`ifdef MEM_RESP_WAIT_EN
          cnt_d = WaitLoad;
`endif
        end
      end
      StWait: begin
`ifdef MEM_RESP_WAIT_EN
        if (cnt_q == 4'd1) begin
          go_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
`else
        state_d = StIdle;
`endif
      end
      StAck, StIllegal: begin
        if (!READ && !WRITE) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_ack) begin
      state_d = StAck;
      err_d   = oor_q;
`ifdef MEM_RESP_WAIT_EN
      cnt_d   = 4'd0;
`endif
      if (op_q == OpWrite) begin
        arr_we = !oor_q;
      end else begin
        rdata_d = oor_q ? '0 : arr_rdata;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      op_q    <= OpRead;
      acc_q   <= 1'b0;
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_RESP_WAIT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      oor_q   <= oor_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_RESP_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  logic data_oe;
  assign data_oe = (state_q == StAck) && (op_q == OpRead);
  assign DATA    = data_oe ? rdata_q : 'z;
  assign READY   = (state_q == StAck) || (state_q == StIllegal);
  assign ERR     = err_q;

endmodule
